// File: rtl/aud_recorder.sv
// -----------------------------------------------------------------------------
// aud_recorder
//   Captures the left-channel I2S word from the WM8731 ADC (AUD_ADCDAT),
//   assembles 16-bit two's-complement samples and issues one SRAM write per
//   sample at sequential word addresses. Recording is controlled by one-cycle
//   start / pause / stop pulses. Everything runs on the rising edge of AUD_BCLK.
//
// Parameters
//   MAX_ADDR     highest SRAM word address written; a write there ends recording
//
// Ports
//   i_clk        AUD_BCLK
//   i_rst_n      asynchronous active-low reset
//   i_lrc        AUD_ADCLRCK, low = left channel
//   i_data       AUD_ADCDAT, MSB first with the I2S one-bit delay
//   i_start      pulse: start from idle, or resume from pause
//   i_pause      pulse: pause
//   i_stop       pulse: stop
//   o_address    SRAM word address of the current/next write
//   o_data       assembled sample, valid while o_valid = 1
//   o_valid      one-cycle SRAM write strobe
//   o_recording  high while waiting for, receiving or writing a sample
//   o_full       high once the write at MAX_ADDR has been made
//   o_count      samples written since the last start from idle
//
// State   | Meaning
// --------+-------------------------------------------------------------
// S_IDLE  | stopped; address/count keep the last recording's length
// S_WAIT  | armed, waiting for an lrc falling edge (left frame start)
// S_RECV  | shifting in the 16 left-channel bits
// S_WRITE | o_valid high for one cycle; address/count advance after it
// S_PAUSE | paused; address/count held, start resumes at the next frame
// S_DONE  | MAX_ADDR written; only stop leaves
// -----------------------------------------------------------------------------
module aud_recorder #(
    parameter logic [19:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lrc,
    input  logic        i_data,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_stop,
    output logic [19:0] o_address,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_recording,
    output logic        o_full,
    output logic [20:0] o_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RECV,
        S_WRITE,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_lrc_d;
    logic [15:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic [19:0] r_address;
    logic [15:0] r_data;
    logic        r_valid;
    logic        r_recording;
    logic        r_full;
    logic [20:0] r_count;

    logic w_frame_start;
    logic w_cmd_stop;
    logic w_cmd_pause;
    logic w_cmd_start;

    assign w_frame_start = r_lrc_d & ~i_lrc;

    // Only the highest-priority pulse in a cycle is considered at all.
    assign w_cmd_stop  = i_stop;
    assign w_cmd_pause = i_pause & ~i_stop;
    assign w_cmd_start = i_start & ~i_pause & ~i_stop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_lrc_d     <= 1'b1;
            r_shift     <= 16'd0;
            r_bit_cnt   <= 5'd0;
            r_address   <= 20'd0;
            r_data      <= 16'd0;
            r_valid     <= 1'b0;
            r_recording <= 1'b0;
            r_full      <= 1'b0;
            r_count     <= 21'd0;
        end else begin
            r_lrc_d <= i_lrc;
            r_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_start) begin
                        r_address   <= 20'd0;
                        r_count     <= 21'd0;
                        r_recording <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (w_cmd_stop) begin
                        r_recording <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_cmd_pause) begin
                        r_recording <= 1'b0;
                        r_state     <= S_PAUSE;
                    end else if (w_frame_start) begin
                        // This edge is the I2S delay slot: nothing captured yet.
                        r_bit_cnt <= 5'd0;
                        r_state   <= S_RECV;
                    end
                end

                S_RECV: begin
                    if (w_cmd_stop) begin
                        r_recording <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_cmd_pause) begin
                        r_recording <= 1'b0;
                        r_state     <= S_PAUSE;
                    end else if (r_bit_cnt == 5'd16) begin
                        // All 16 bits are in; later bits of a longer word are
                        // ignored because S_WAIT only re-arms on the next fall.
                        r_data    <= r_shift;
                        r_valid   <= 1'b1;
                        r_state   <= S_WRITE;
                    end else begin
                        r_shift   <= {r_shift[14:0], i_data};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end

                S_WRITE: begin
                    // The strobe has already gone out, so the write is always
                    // counted, whatever command arrives now.
                    r_count <= r_count + 21'd1;
                    if (r_address != MAX_ADDR) begin
                        r_address <= r_address + 20'd1;
                    end
                    if (w_cmd_stop) begin
                        r_recording <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (r_address == MAX_ADDR) begin
                        r_recording <= 1'b0;
                        r_full      <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_cmd_pause) begin
                        r_recording <= 1'b0;
                        r_state     <= S_PAUSE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end

                S_PAUSE: begin
                    if (w_cmd_stop) begin
                        r_state <= S_IDLE;
                    end else if (w_cmd_start) begin
                        r_recording <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end

                S_DONE: begin
                    if (w_cmd_stop) begin
                        r_full  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_recording <= 1'b0;
                    r_full      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_address   = r_address;
    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_recording = r_recording;
    assign o_full      = r_full;
    assign o_count     = r_count;

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: a behavioural recorder model (mode + bit history)
// is compared against the DUT every cycle, plus literal checks per scenario.
module tb_aud_recorder;

    localparam logic [19:0] MAX = 20'd3;

    logic        clk;
    logic        rst_n;
    logic        i_lrc, i_data, i_start, i_pause, i_stop;
    logic [19:0] o_address;
    logic [15:0] o_data;
    logic        o_valid, o_recording, o_full;
    logic [20:0] o_count;

    aud_recorder #(.MAX_ADDR(MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lrc(i_lrc), .i_data(i_data),
        .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
        .o_address(o_address), .o_data(o_data), .o_valid(o_valid),
        .o_recording(o_recording), .o_full(o_full), .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 stopped, 1 recording, 2 paused, 3 full
    int          cyc = 0;
    int          m_mode;
    bit          m_in_frame;
    int          m_fall;
    bit          m_pend;
    logic [19:0] m_addr;
    logic [20:0] m_count;
    logic [15:0] m_data;
    logic        m_prev_lrc;
    logic        hist [64];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_in_frame = 0; m_pend = 0;
            m_addr = 0; m_count = 0; m_data = 0; m_prev_lrc = 1'b1;
        end else begin
            bit c_stop, c_pause, c_start;
            cyc = cyc + 1;
            hist[cyc % 64] = i_data;
            c_stop  = i_stop;
            c_pause = i_pause && !i_stop;
            c_start = i_start && !i_pause && !i_stop;
            if (m_pend) begin
                m_pend = 0;
                m_in_frame = 0;
                m_count = m_count + 1;
                if (m_addr == MAX) m_mode = c_stop ? 0 : 3;
                else begin
                    m_addr = m_addr + 1;
                    m_mode = c_stop ? 0 : (c_pause ? 2 : 1);
                end
            end else begin
                case (m_mode)
                    0: if (c_start) begin
                        m_addr = 0; m_count = 0; m_mode = 1; m_in_frame = 0;
                    end
                    1: if (c_stop) m_mode = 0;
                       else if (c_pause) m_mode = 2;
                       else if (!m_in_frame) begin
                           if (m_prev_lrc && !i_lrc) begin
                               m_in_frame = 1; m_fall = cyc;
                           end
                       end else if (cyc - m_fall == 17) begin
                           for (int k = 0; k < 16; k++)
                               m_data[15-k] = hist[(m_fall + 1 + k) % 64];
                           m_pend = 1;
                       end
                    2: if (c_stop) m_mode = 0;
                       else if (c_start) begin m_mode = 1; m_in_frame = 0; end
                    default: if (c_stop) m_mode = 0;
                endcase
            end
            m_prev_lrc = i_lrc;
        end
    end

    // ---------------- compare / write monitor ----------------
    logic [19:0] wq_a[$];
    logic [15:0] wq_d[$];
    int          valid_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid",     32'(o_valid),     32'(m_pend));
            chk("address",   32'(o_address),   32'(m_addr));
            chk("count",     32'(o_count),     32'(m_count));
            chk("data",      32'(o_data),      32'(m_data));
            chk("recording", 32'(o_recording), 32'((m_mode == 1) || m_pend));
            chk("full",      32'(o_full),      32'(m_mode == 3));
            if (o_valid) begin
                wq_a.push_back(o_address);
                wq_d.push_back(o_data);
                valid_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int fall_cyc = 0;

    task automatic drive(input logic lrc, input logic d, input logic st,
                         input logic pa, input logic sp);
        i_lrc = lrc; i_data = d; i_start = st; i_pause = pa; i_stop = sp;
        @(negedge clk);
    endtask

    task automatic cmd(input logic st, input logic pa, input logic sp);
        drive(1'b1, 1'b0, st, pa, sp);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw,
                              input int half, input int pause_at, input int stop_at);
        for (int i = 0; i < half; i++) begin
            if (i == 0) fall_cyc = cyc + 1;
            drive(1'b0, (i >= 1 && i <= 16) ? lw[16-i] : 1'($urandom),
                  1'b0, 1'(i == pause_at), 1'(i == stop_at));
        end
        for (int i = 0; i < half; i++)
            drive(1'b1, (i >= 1 && i <= 16) ? rw[16-i] : 1'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_wq();
        wq_a.delete();
        wq_d.delete();
    endtask

    logic [15:0] words [6];

    initial begin
        rst_n = 1'b0;
        i_lrc = 1'b1; i_data = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_address", 32'(o_address), 32'd0);
        chk("rst_count",   32'(o_count),   32'd0);
        chk("rst_valid",   32'(o_valid),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset and one sample
        clear_wq();
        cmd(1'b1, 1'b0, 1'b0);
        send_frame(16'hA5C3, 16'h5A5A, 32, -1, -1);
        chk("t1_nwrites", 32'(wq_a.size()), 32'd1);
        if (wq_a.size() == 1) begin
            chk("t1_addr", 32'(wq_a[0]), 32'd0);
            chk("t1_data", 32'(wq_d[0]), 32'hA5C3);
        end
        chk("t1_latency", 32'(valid_cyc - fall_cyc), 32'd17);
        chk("t1_addr_after",  32'(o_address), 32'd1);
        chk("t1_count_after", 32'(o_count),   32'd1);

        // Consecutive frames, running into full at MAX = 3, then 2 extra frames
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        clear_wq();
        words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF;
        words[3] = 16'h1234; words[4] = 16'h4321; words[5] = 16'h0F0F;
        for (int f = 0; f < 6; f++) send_frame(words[f], 16'hDEAD, 32, -1, -1);
        chk("full_nwrites", 32'(wq_a.size()), 32'd4);
        for (int f = 0; f < 4 && f < wq_a.size(); f++) begin
            chk("seq_addr", 32'(wq_a[f]), 32'(f));
            chk("seq_data", 32'(wq_d[f]), 32'(words[f]));
        end
        chk("full_flag",  32'(o_full),  32'd1);
        chk("full_count", 32'(o_count), 32'd4);
        cmd(1'b1, 1'b0, 1'b0);
        chk("full_ignores_start", 32'(o_full), 32'd1);
        cmd(1'b0, 1'b0, 1'b1);
        chk("stop_full_flag",  32'(o_full),      32'd0);
        chk("stop_full_rec",   32'(o_recording), 32'd0);
        chk("stop_full_count", 32'(o_count),     32'd4);

        // Pause mid-sample
        cmd(1'b1, 1'b0, 1'b0);
        clear_wq();
        send_frame(16'h1111, 16'hDEAD, 32, -1, -1);
        send_frame(16'h2222, 16'hDEAD, 32, 8, -1);
        cmd(1'b1, 1'b0, 1'b0);
        send_frame(16'h7777, 16'hDEAD, 32, -1, -1);
        chk("pause_nwrites", 32'(wq_a.size()), 32'd2);
        if (wq_a.size() == 2) begin
            chk("pause_addr", 32'(wq_a[1]), 32'd1);
            chk("pause_data", 32'(wq_d[1]), 32'h7777);
        end
        chk("pause_count", 32'(o_count), 32'd2);

        // Stop in the write cycle
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        clear_wq();
        send_frame(16'h4242, 16'hDEAD, 32, -1, -1);
        send_frame(16'h5151, 16'hDEAD, 32, -1, 18);
        chk("stopw_nwrites", 32'(wq_a.size()), 32'd2);
        chk("stopw_count",   32'(o_count),     32'd2);
        chk("stopw_rec",     32'(o_recording), 32'd0);
        cmd(1'b1, 1'b0, 1'b0);
        chk("restart_addr",  32'(o_address), 32'd0);
        chk("restart_count", 32'(o_count),   32'd0);

        // Async reset during reception
        send_frame(16'hBEEF, 16'hDEAD, 32, -1, -1);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_address", 32'(o_address),   32'd0);
        chk("arst_data",    32'(o_data),      32'd0);
        chk("arst_count",   32'(o_count),     32'd0);
        chk("arst_rec",     32'(o_recording), 32'd0);
        chk("arst_valid",   32'(o_valid),     32'd0);
        i_lrc = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized frames and commands, one command per cycle at most
        cmd(1'b1, 1'b0, 1'b0);
        for (int f = 0; f < 60; f++) begin
            int half;
            half = $urandom_range(18, 40);
            for (int i = 0; i < 2 * half; i++) begin
                int r;
                r = $urandom_range(0, 199);
                drive(1'(i >= half), 1'($urandom), 1'(r < 6), 1'(r == 6),
                      1'(r == 7 && ($urandom_range(0, 2) == 0)));
            end
        end
        cmd(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/aud_recorder.md
# aud_recorder

Serial-to-parallel capture engine for the WM8731 ADC path. It shifts the left-channel I2S word in from AUD_ADCDAT, assembles 16-bit two's-complement samples, and presents one SRAM write per sample at sequential addresses. It sits inside Top next to the audio player: the player reads samples out of SRAM to the DAC, and this block writes them in from the ADC. The record/pause/stop commands come from debounced key pulses through Top's control FSM.

## Interface
- MAX_ADDR, default 20'hFFFFF: highest SRAM word address written; a write here ends recording.
- i_clk  in  1  AUD_BCLK (single clock domain; all logic on rising edge)
- i_rst_n  in  1  asynchronous, active-low reset
- i_lrc  in  1  AUD_ADCLRCK; low = left channel
- i_data  in  1  AUD_ADCDAT, MSB-first, I2S one-bit delay
- i_start  in  1  one-cycle pulse: start, or resume from pause
- i_pause  in  1  one-cycle pulse: pause
- i_stop  in  1  one-cycle pulse: stop
- o_address  out  20  SRAM word address of the current/next write
- o_data  out  16  assembled sample; valid while o_valid=1
- o_valid  out  1  one-cycle SRAM write strobe
- o_recording  out  1  high in S_WAIT/S_RECV/S_WRITE
- o_full  out  1  high in S_DONE
- o_count  out  21  samples written since the last start from idle

## Operation
- The FSM has six states: S_IDLE, S_WAIT, S_RECV, S_WRITE, S_PAUSE, S_DONE.
- lrc_d is a register of i_lrc. A left-frame start is a falling edge: lrc_d=1 && i_lrc=0.
- Command priority within a cycle is stop > pause > start.
- Commands only take effect in the states listed below. Any command not listed for a state is ignored in that state.
- S_IDLE:
  - On i_start: clear o_address and o_count to 0, then go to S_WAIT.
- S_WAIT:
  - On a left-frame start: clear the bit counter, then go to S_RECV.
  - The detection cycle itself is the I2S delay slot; no bit is captured in it.
- S_RECV:
  - Each cycle: shift_reg <= {shift_reg[14:0], i_data}, and the counter increments.
  - After the 16th bit: load o_data with the full word and go to S_WRITE.
- S_WRITE:
  - o_valid=1 for exactly one cycle; o_address and o_data are stable during it.
  - Next cycle:
    - o_count increments.
    - If o_address == MAX_ADDR: go to S_DONE and leave o_address unchanged.
    - Otherwise: o_address increments and the FSM goes to S_WAIT.
- i_pause in S_WAIT or S_RECV:
  - Go to S_PAUSE. A partial sample is discarded; o_address and o_count are held.
- i_pause in S_WRITE:
  - The write completes (o_valid is already high) and its count/address update happens.
  - Then go to S_PAUSE instead of S_WAIT.
- S_PAUSE:
  - On i_start: go to S_WAIT; the address is kept, so recording resumes at the next left frame.
- i_stop in any non-IDLE state:
  - Go to S_IDLE; o_address and o_count keep their values for playback length.
  - If i_stop arrives in S_WRITE, the write still completes and is counted.
- S_DONE:
  - i_start and i_pause are ignored; only i_stop leaves the state.
- The right channel is never captured.
- Words longer than 16 bits are truncated to the first 16 bits; anything after bit 16 is ignored until the next frame start.
- Width rule: o_count is 21 bits so that a full 2^20-word recording reports 1048576 without wrapping.

## Timing
- Reset (asynchronous, any state) forces:
  - State S_IDLE, o_address=0, o_data=0, o_valid=0, o_recording=0, o_full=0, o_count=0, lrc_d=1.
  - This applies mid-sample and mid-write; the write is dropped.
- Let the lrc falling edge be detected at rising edge T.
  - Bit 15 is captured at T+1, and bit 0 at T+16.
  - o_valid=1 in cycle T+17.
  - o_address and o_count update at T+18.
- The left half-frame must be at least 18 BCLK cycles long. The codec configuration guarantees 32 or more.
- i_start to first capture: 1 cycle to enter S_WAIT, then wait for the next lrc falling edge.
- Command pulses are sampled on every rising edge and are never queued.

## Test plan
- Reset and one sample:
  - Stimulus: reset, i_start, then an I2S left word 16'hA5C3.
  - Required: o_valid pulses exactly once, 17 cycles after the lrc fall, with o_data=16'hA5C3 and o_address=0. Afterwards o_address=1 and o_count=1.
- Consecutive frames:
  - Stimulus: 4 frames with left=16'h0001, 16'h8000, 16'hFFFF, 16'h1234 and right=16'hDEAD.
  - Required: writes go to addresses 0..3 with exactly the left values; the right word is never written.
- Pause mid-sample:
  - Stimulus: i_pause at bit 8 of the second sample, then i_start, then a third frame 16'h7777.
  - Required: no write for the aborted sample; 16'h7777 lands at address 1; o_count=2.
- Full:
  - Stimulus: MAX_ADDR=3, feed 6 frames.
  - Required: 4 writes at addresses 0..3, then o_full=1 and o_count=4; i_start is ignored until i_stop, after which the FSM is in S_IDLE with o_count=4.
- Edge cases:
  - i_stop asserted in the S_WRITE cycle: the write is counted and the FSM goes to S_IDLE.
  - i_start from S_IDLE after that: o_address=0 and o_count=0.
  - Async reset asserted during S_RECV: all outputs go to 0 immediately.
